// File: rtl/junction_ctrl_pkg.sv
// rtl/junction_ctrl_pkg.sv - shared state encoding and default constants for the junction dose sequencer
//
// Contents:
//   seq_state_t       sequencer FSM states (IDLE, DOSE, DWELL, DRAIN)
//   DEF_*             default parameter values for the sequencer
//   max_int()         elaboration-time helper for sizing counters
package junction_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DOSE  = 2'd1,
        DWELL = 2'd2,
        DRAIN = 2'd3
    } seq_state_t;

    localparam int DEF_CNT_W        = 16;
    localparam int DEF_STEP_DIV     = 4;
    localparam int DEF_RESID_CYCLES = 64;
    localparam int DEF_DRAIN_CYCLES = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dose_channel.sv
// rtl/dose_channel.sv - one inlet channel: remaining step count, inlet valve and pump step pulse
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         latch count as the remaining steps for a new sequence
//   count        number of pump steps for this channel
//   tick         shared divider strobe; one step is issued on the following cycle
//   clear        abort: drop the remaining count, close the valve, cancel any step
//   valve        inlet valve open (registered)
//   step         one-cycle pump step pulse (registered)
//   empty        no steps remaining
module dose_channel #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] count,
    input  logic             tick,
    input  logic             clear,
    output logic             valve,
    output logic             step,
    output logic             empty
);

    logic [CNT_W-1:0] remain;
    logic             fire;

    assign empty = (remain == '0);
    assign fire  = tick && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain <= '0;
            valve  <= 1'b0;
            step   <= 1'b0;
        end else if (clear) begin
            remain <= '0;
            valve  <= 1'b0;
            step   <= 1'b0;
        end else if (load) begin
            remain <= count;
            valve  <= (count != '0);
            step   <= 1'b0;
        end else begin
            step <= fire;
            if (fire) begin
                remain <= remain - CNT_W'(1);
            end
            // Sampling the count before the decrement keeps the valve open
            // through the cycle that carries the final step pulse.
            valve <= !empty;
        end
    end

endmodule

// File: rtl/junction_dose_sequencer.sv
// rtl/junction_dose_sequencer.sv - two-inlet dose / dwell / drain sequencer for the diffusion-mixer junction
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   cmd_valid, cmd_ready     dose command handshake (ready only in IDLE)
//   cmd_dose_a, cmd_dose_b   pump step counts, latched on acceptance
//   abort                    cancel the running sequence; blocks acceptance in IDLE
//   valve_a, valve_b         inlet valves
//   step_a, step_b           pump step pulses
//   valve_out                outlet valve
//   busy                     sequence in progress
//   done, aborted, err       one-cycle completion / cancel / reject pulses
module junction_dose_sequencer
    import junction_ctrl_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int STEP_DIV     = DEF_STEP_DIV,
    parameter int RESID_CYCLES = DEF_RESID_CYCLES,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_dose_a,
    input  logic [CNT_W-1:0] cmd_dose_b,
    input  logic             abort,
    output logic             valve_a,
    output logic             valve_b,
    output logic             step_a,
    output logic             step_b,
    output logic             valve_out,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             err
);

    localparam int DIV_W = $clog2(STEP_DIV);
    localparam int TMR_W = $clog2(max_int(RESID_CYCLES, DRAIN_CYCLES) + 1);

    // Steps are registered, so the channels are told one cycle early:
    // a tick while the divider sits at STEP_DIV-2 puts the step pulse in
    // the cycle where the divider reads STEP_DIV-1.
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(STEP_DIV - 2);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [TMR_W-1:0] RESID_LD = TMR_W'(RESID_CYCLES - 1);
    localparam logic [TMR_W-1:0] DRAIN_LD = TMR_W'(DRAIN_CYCLES - 1);

    seq_state_t       state;
    seq_state_t       state_next;
    logic [DIV_W-1:0] div;
    logic [TMR_W-1:0] tmr;

    logic             accept;
    logic             start;
    logic             reject;
    logic             abort_hit;
    logic             drain_end;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_value;
    logic             tick;
    logic             empty_a;
    logic             empty_b;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        accept     = cmd_valid && (state == IDLE) && !abort;
        start      = accept && ((cmd_dose_a != '0) || (cmd_dose_b != '0));
        reject     = accept && (cmd_dose_a == '0) && (cmd_dose_b == '0);
        abort_hit  = abort && (state != IDLE);
        drain_end  = 1'b0;
        tmr_load   = 1'b0;
        tmr_value  = '0;
        tick       = (state == DOSE) && (div == DIV_PRE) && !abort;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = DOSE;
                end
            end
            DOSE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (empty_a && empty_b) begin
                    state_next = DWELL;
                    tmr_load   = 1'b1;
                    tmr_value  = RESID_LD;
                end
            end
            DWELL: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (tmr == '0) begin
                    state_next = DRAIN;
                    tmr_load   = 1'b1;
                    tmr_value  = DRAIN_LD;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (tmr == '0) begin
                    state_next = IDLE;
                    drain_end  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, divider, shared dwell/drain timer and status pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            div       <= '0;
            tmr       <= '0;
            valve_out <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_next;

            if (start) begin
                div <= '0;
            end else if (state == DOSE) begin
                div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
            end

            if (tmr_load) begin
                tmr <= tmr_value;
            end else if (tmr != '0) begin
                tmr <= tmr - TMR_W'(1);
            end

            valve_out <= (state_next == DRAIN);
            done      <= drain_end;
            aborted   <= abort_hit;
            err       <= reject;
        end
    end

    // ------------------------------------------------------------------
    // Inlet channels
    // ------------------------------------------------------------------
    dose_channel #(
        .CNT_W (CNT_W)
    ) u_chan_a (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start),
        .count (cmd_dose_a),
        .tick  (tick),
        .clear (abort_hit),
        .valve (valve_a),
        .step  (step_a),
        .empty (empty_a)
    );

    dose_channel #(
        .CNT_W (CNT_W)
    ) u_chan_b (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start),
        .count (cmd_dose_b),
        .tick  (tick),
        .clear (abort_hit),
        .valve (valve_b),
        .step  (step_b),
        .empty (empty_b)
    );

endmodule
